// File: rtl/ddr_app_pkg.sv
// Shared constants and command-queue entry type for the DDR app_* interface.
// Initiators import the same opcodes so both sides agree on encoding.
package ddr_app_pkg;

  localparam logic [2:0] WR_CMD = 3'b000;
  localparam logic [2:0] RD_CMD = 3'b001;

  // Widest word index any instance may use; narrower instances zero-extend.
  localparam int unsigned MAX_INDEX_WIDTH = 24;

  typedef struct packed {
    logic [2:0]                 cmd;
    logic [MAX_INDEX_WIDTH-1:0] index;
  } cmd_entry_t;

  function automatic logic cmd_is_valid(logic [2:0] cmd);
    return (cmd == WR_CMD) || (cmd == RD_CMD);
  endfunction

endpackage

// File: rtl/ddr_app_bram_responder_if.sv
// DDR controller user (app_*) port bundle.
// The master side is the initiator; the slave side is the memory controller or its stand-in.
interface ddr_app_bram_responder_if #(
  parameter int unsigned APP_DATA_WIDTH = 64,
  parameter int unsigned APP_ADDR_WIDTH = 32,
  parameter int unsigned APP_MASK_WIDTH = 8
);

  logic                      init_calib_complete;
  logic [APP_ADDR_WIDTH-1:0] app_addr;
  logic [2:0]                app_cmd;
  logic                      app_en;
  logic                      app_rdy;
  logic [APP_DATA_WIDTH-1:0] app_wdf_data;
  logic [APP_MASK_WIDTH-1:0] app_wdf_mask;
  logic                      app_wdf_wren;
  logic                      app_wdf_end;
  logic                      app_wdf_rdy;
  logic [APP_DATA_WIDTH-1:0] app_rd_data;
  logic                      app_rd_data_valid;
  logic                      app_rd_data_end;
  logic                      protocol_err;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    input  app_rd_data_end, protocol_err
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    output app_rd_data_end, protocol_err
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags; push while full is allowed when a pop
// happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/ddr_app_bram_responder.sv
// BRAM-backed stand-in for the DDR controller app_* interface, with calibration
// delay, in-order command execution and optional periodic app_rdy backpressure.
module ddr_app_bram_responder
  import ddr_app_pkg::*;
#(
  parameter int unsigned APP_DATA_WIDTH  = 64,
  parameter int unsigned APP_ADDR_WIDTH  = 32,
  parameter int unsigned APP_MASK_WIDTH  = 8,
  parameter int unsigned DDR_ADDR_STRIDE = 8,
  parameter int unsigned DEPTH_WIDTH     = 10,
  parameter int unsigned CALIB_CYCLES    = 16,
  parameter int unsigned RD_LATENCY      = 4,
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter int unsigned BUSY_PERIOD     = 0
) (
  input logic                     clk,
  input logic                     rst_n,
  ddr_app_bram_responder_if.slave app
);

  localparam int unsigned STRIDE_SHIFT = $clog2(DDR_ADDR_STRIDE);
  localparam int unsigned MEM_DEPTH    = 1 << DEPTH_WIDTH;
  localparam int unsigned CAL_W        = $clog2(CALIB_CYCLES + 1);
  localparam int unsigned ENTRY_W      = $bits(cmd_entry_t);
  localparam int unsigned WDF_W        = APP_DATA_WIDTH + APP_MASK_WIDTH;

  typedef enum logic [1:0] {StIdle, StExec, StWaitWdata} head_state_e;

  // Calibration delay
  logic [CAL_W-1:0] cal_cnt_q;
  logic             calib_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cal_cnt_q <= '0;
      calib_q   <= 1'b0;
    end else if (!calib_q) begin
      cal_cnt_q <= cal_cnt_q + CAL_W'(1);
      if (cal_cnt_q == CAL_W'(CALIB_CYCLES - 1)) calib_q <= 1'b1;
    end
  end

  // Busy-slot injection
  logic busy_slot;

  if (BUSY_PERIOD == 0) begin : g_no_busy
    assign busy_slot = 1'b0;
  end else begin : g_busy
    localparam int unsigned BusyW = (BUSY_PERIOD > 1) ? $clog2(BUSY_PERIOD) : 1;
    logic [BusyW-1:0] busy_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        busy_cnt_q <= '0;
      end else if (busy_cnt_q == BusyW'(BUSY_PERIOD - 1)) begin
        busy_cnt_q <= '0;
      end else begin
        busy_cnt_q <= busy_cnt_q + BusyW'(1);
      end
    end

    assign busy_slot = (busy_cnt_q == BusyW'(BUSY_PERIOD - 1));
  end

  // Queues
  logic               cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic               wdf_push, wdf_pop, wdf_full, wdf_empty;
  logic               cmd_accept, wdf_accept;
  cmd_entry_t         cmd_in, cmd_head;
  logic [ENTRY_W-1:0] cmd_head_raw;
  logic [WDF_W-1:0]   wdf_head;

  assign cmd_accept   = app.app_en & app.app_rdy;
  assign wdf_accept   = app.app_wdf_wren & app.app_wdf_rdy;
  assign cmd_push     = cmd_accept & cmd_is_valid(app.app_cmd);
  assign wdf_push     = wdf_accept;
  assign cmd_in.cmd   = app.app_cmd;
  assign cmd_in.index = MAX_INDEX_WIDTH'(app.app_addr[STRIDE_SHIFT +: DEPTH_WIDTH]);
  assign cmd_head     = cmd_entry_t'(cmd_head_raw);

  // Sub-stride and above-depth address bits alias by design.
  logic unused_addr;
  logic unused_head_index;
  assign unused_addr       = ^app.app_addr;
  assign unused_head_index = ^cmd_head.index;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_push),
    .wdata (cmd_in),
    .pop   (cmd_pop),
    .rdata (cmd_head_raw),
    .full  (cmd_full),
    .empty (cmd_empty)
  );

  sync_fifo #(
    .WIDTH (WDF_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_wdf_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wdf_push),
    .wdata ({app.app_wdf_data, app.app_wdf_mask}),
    .pop   (wdf_pop),
    .rdata (wdf_head),
    .full  (wdf_full),
    .empty (wdf_empty)
  );

  logic [APP_DATA_WIDTH-1:0] wdf_data;
  logic [APP_MASK_WIDTH-1:0] wdf_mask;
  logic [DEPTH_WIDTH-1:0]    head_index;
  logic                      head_is_read;

  assign wdf_data     = wdf_head[WDF_W-1 -: APP_DATA_WIDTH];
  assign wdf_mask     = wdf_head[APP_MASK_WIDTH-1:0];
  assign head_index   = cmd_head.index[DEPTH_WIDTH-1:0];
  assign head_is_read = (cmd_head.cmd == RD_CMD);

  // Head processor
  head_state_e state_q, state_d;
  logic        mem_we, mem_re;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cmd_pop = 1'b0;
    wdf_pop = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    case (state_q)
      StIdle, StExec: begin
        state_d = StIdle;
        if (!cmd_empty) begin
          if (head_is_read) begin
            mem_re  = 1'b1;
            cmd_pop = 1'b1;
            state_d = StExec;
          end else if (!wdf_empty) begin
            mem_we  = 1'b1;
            cmd_pop = 1'b1;
            wdf_pop = 1'b1;
            state_d = StExec;
          end else begin
            state_d = StWaitWdata;
          end
        end
      end
      StWaitWdata: begin
        if (!wdf_empty) begin
          mem_we  = 1'b1;
          cmd_pop = 1'b1;
          wdf_pop = 1'b1;
          state_d = StExec;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Ready depends only on registered state; pop is decoded from queue heads.
  assign app.app_rdy     = calib_q & (~cmd_full | cmd_pop) & ~busy_slot;
  assign app.app_wdf_rdy = calib_q & (~wdf_full | wdf_pop);

  // Block RAM: contents survive reset.
  logic [APP_DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [APP_DATA_WIDTH-1:0] bram_rd_q;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < int'(APP_MASK_WIDTH); b++) begin
        if (!wdf_mask[b]) mem[head_index][b*8 +: 8] <= wdf_data[b*8 +: 8];
      end
    end
    if (mem_re) bram_rd_q <= mem[head_index];
  end

  // Read return pipeline
  logic                      rd_issue_q;
  logic [RD_LATENCY-1:0]     pipe_valid_q;
  logic [APP_DATA_WIDTH-1:0] pipe_data_q [RD_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_issue_q   <= 1'b0;
      pipe_valid_q <= '0;
      for (int i = 0; i < int'(RD_LATENCY); i++) pipe_data_q[i] <= '0;
    end else begin
      rd_issue_q      <= mem_re;
      pipe_valid_q[0] <= rd_issue_q;
      pipe_data_q[0]  <= rd_issue_q ? bram_rd_q : '0;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_data_q[i]  <= pipe_data_q[i-1];
      end
    end
  end

  // Sticky protocol error
  logic err_q, err_set;

  assign err_set = (cmd_accept & ~cmd_is_valid(app.app_cmd))
                 | (wdf_accept & (app.app_wdf_end != app.app_wdf_wren))
                 | (~calib_q & (app.app_en | app.app_wdf_wren));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign app.init_calib_complete = calib_q;
  assign app.protocol_err        = err_q;
  assign app.app_rd_data         = pipe_data_q[RD_LATENCY-1];
  assign app.app_rd_data_valid   = pipe_valid_q[RD_LATENCY-1];
  assign app.app_rd_data_end     = pipe_valid_q[RD_LATENCY-1];

endmodule

// File: tb/tb_ddr_app_bram_responder.sv
// Scoreboard bench for ddr_app_bram_responder: an untimed in-order memory model
// predicts read data; a negedge monitor checks returns, calibration, busy slots and errors.
module tb_ddr_app_bram_responder;
  import ddr_app_pkg::*;

  localparam int unsigned CALIB = 16;
  localparam int unsigned RDLAT = 4;
  localparam int unsigned BUSY  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ddr_app_bram_responder_if app_bus ();

  ddr_app_bram_responder #(
    .CALIB_CYCLES (CALIB),
    .RD_LATENCY   (RDLAT),
    .BUSY_PERIOD  (BUSY)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .app   (app_bus)
  );

  typedef struct {bit rd; int idx; int cyc; bit chk;} mcmd_t;
  typedef struct {logic [63:0] d; logic [7:0] m;} beat_t;
  typedef struct {logic [63:0] d; int cyc; bit chk;} exp_t;
  typedef struct {bit rd; logic [31:0] addr;} op_t;

  mcmd_t       mq[$];
  beat_t       dq[$];
  exp_t        sb[$];
  logic [63:0] mem_m [int];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int rcyc = 0;
  bit prot_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rcyc <= 0;
    else        rcyc <= rcyc + 1;
  end

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Untimed memory semantics: commands retire strictly in order, writes consume beats in order.
  function automatic void model_step();
    while (mq.size() > 0) begin
      if (mq[0].rd) begin
        exp_t e;
        e.d   = mem_m.exists(mq[0].idx) ? mem_m[mq[0].idx] : 64'h0;
        e.cyc = mq[0].cyc;
        e.chk = mq[0].chk;
        sb.push_back(e);
        void'(mq.pop_front());
      end else if (dq.size() > 0) begin
        logic [63:0] cur;
        cur = mem_m.exists(mq[0].idx) ? mem_m[mq[0].idx] : 64'h0;
        for (int b = 0; b < 8; b++) if (!dq[0].m[b]) cur[b*8 +: 8] = dq[0].d[b*8 +: 8];
        mem_m[mq[0].idx] = cur;
        void'(mq.pop_front());
        void'(dq.pop_front());
      end else begin
        break;
      end
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] cmd, input logic [31:0] addr, input bit chk_lat);
    bit acc = 0;
    app_bus.app_en   = 1'b1;
    app_bus.app_cmd  = cmd;
    app_bus.app_addr = addr;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = app_bus.app_rdy;
      @(posedge clk);
      #1;
    end
    app_bus.app_en = 1'b0;
    check("cmd_accepted", acc, 1);
    if (acc) begin
      if (cmd == RD_CMD || cmd == WR_CMD) begin
        mq.push_back('{cmd == RD_CMD, int'((addr / 8) % 1024), cyc, chk_lat});
        model_step();
      end else begin
        prot_exp = 1'b1;
      end
    end
  endtask

  task automatic send_wdf(input logic [63:0] d, input logic [7:0] m, input bit endb);
    bit acc = 0;
    app_bus.app_wdf_wren = 1'b1;
    app_bus.app_wdf_end  = endb;
    app_bus.app_wdf_data = d;
    app_bus.app_wdf_mask = m;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = app_bus.app_wdf_rdy;
      @(posedge clk);
      #1;
    end
    app_bus.app_wdf_wren = 1'b0;
    app_bus.app_wdf_end  = 1'b0;
    check("wdf_accepted", acc, 1);
    if (acc) begin
      dq.push_back('{d, m});
      if (!endb) prot_exp = 1'b1;
      model_step();
    end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 500 && (sb.size() != 0 || mq.size() != 0); n++) idle(1);
    idle(RDLAT + 4);
    check("drain_outstanding", sb.size() + mq.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mq.delete();
    dq.delete();
    sb.delete();
    prot_exp = 1'b0;
    idle(3);
    rst_n = 1'b1;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_rd_valid", app_bus.app_rd_data_valid, 0);
      check("reset_calib", app_bus.init_calib_complete, 0);
      check("reset_protocol_err", app_bus.protocol_err, 0);
    end else begin
      if (rcyc <= CALIB + 1) check("calib_timing", app_bus.init_calib_complete, rcyc >= CALIB);
      if (rcyc < CALIB) begin
        check("app_rdy_precal", app_bus.app_rdy, 0);
        check("app_wdf_rdy_precal", app_bus.app_wdf_rdy, 0);
      end
      if (app_bus.init_calib_complete && (rcyc % BUSY) == BUSY - 1)
        check("busy_slot_app_rdy", app_bus.app_rdy, 0);
      check("protocol_err", app_bus.protocol_err, prot_exp);
      check("rd_data_end", app_bus.app_rd_data_end, app_bus.app_rd_data_valid);
      if (app_bus.app_rd_data_valid) begin
        if (sb.size() == 0) begin
          check("rd_valid_unexpected", app_bus.app_rd_data_valid, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rd_data", app_bus.app_rd_data, e.d);
          if (e.chk) check("rd_latency", cyc, e.cyc + RDLAT + 1);
        end
      end
    end
  end

  initial begin
    op_t   ops[$];
    beat_t beats[$];
    int    n;

    app_bus.app_en       = 1'b0;
    app_bus.app_cmd      = 3'b000;
    app_bus.app_addr     = '0;
    app_bus.app_wdf_wren = 1'b0;
    app_bus.app_wdf_end  = 1'b0;
    app_bus.app_wdf_data = '0;
    app_bus.app_wdf_mask = '0;

    #1;
    do_reset();

    // Calibration rise
    n = 0;
    while (!app_bus.init_calib_complete && n < 40) begin
      idle(1);
      n++;
    end
    check("calib_rise_cycle", rcyc, CALIB);

    // Write then read with latency check
    fork
      send_cmd(WR_CMD, 32'h40, 0);
      send_wdf(64'hDEAD_BEEF_0000_0001, 8'h00, 1);
    join
    idle(4);
    send_cmd(RD_CMD, 32'h40, 1);
    wait_drain();

    // Command 3 cycles ahead of its data, read queued behind it
    fork
      begin
        send_cmd(WR_CMD, 32'h80, 0);
        send_cmd(RD_CMD, 32'h80, 0);
      end
      begin
        idle(3);
        send_wdf(64'h0123_4567_89AB_CDEF, 8'h00, 1);
      end
    join
    wait_drain();

    // Masked write over zero
    fork
      begin
        send_cmd(WR_CMD, 32'hC0, 0);
        send_cmd(WR_CMD, 32'hC0, 0);
        send_cmd(RD_CMD, 32'hC0, 0);
      end
      begin
        send_wdf(64'h0, 8'h00, 1);
        send_wdf(64'hFFFF_FFFF_FFFF_FFFF, 8'hF0, 1);
      end
    join
    wait_drain();

    // 32-beat burst then read back
    fork
      for (int i = 0; i < 32; i++) send_cmd(WR_CMD, 32'(i * 8), 0);
      for (int i = 0; i < 32; i++) send_wdf({$urandom, $urandom}, 8'h00, 1);
    join
    for (int i = 0; i < 32; i++) send_cmd(RD_CMD, 32'(i * 8), 0);
    wait_drain();

    // Random mix with aliased addresses and random masks
    for (int i = 0; i < 200; i++) begin
      op_t o;
      o.rd   = ($urandom_range(0, 2) == 0);
      o.addr = ($urandom << 13) | (32'($urandom_range(0, 31)) << 3) | 32'($urandom_range(0, 7));
      ops.push_back(o);
      if (!o.rd) beats.push_back('{{$urandom, $urandom}, 8'($urandom_range(0, 255))});
    end
    fork
      foreach (ops[i]) begin
        send_cmd(ops[i].rd ? RD_CMD : WR_CMD, ops[i].addr, 0);
        idle($urandom_range(0, 2));
      end
      foreach (beats[i]) begin
        idle($urandom_range(0, 3));
        send_wdf(beats[i].d, beats[i].m, 1);
      end
    join
    wait_drain();

    // Illegal opcode, then reset during a pending read burst
    send_cmd(3'b010, 32'h0, 0);
    idle(1);
    check("protocol_err_set", app_bus.protocol_err, 1);
    for (int i = 0; i < 8; i++) send_cmd(RD_CMD, 32'(i * 8), 0);
    do_reset();
    check("protocol_err_cleared", app_bus.protocol_err, 0);
    idle(30);
    check("post_reset_outstanding", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, required finish before 2ms");
    $fatal(1);
  end

endmodule
